// File: rtl/demux_1x4_tdm.sv
// Purpose: splits a TDM word stream into four channel registers, locking onto the SYNC frame marker.
// Latency: one cycle; a word sampled at edge n is on Yk with its Y_valid strobe from edge n.
// Backpressure: none; every word with D_valid=1 is consumed, and D_valid=0 gaps of any length are allowed.
module demux_1x4_tdm #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] D,
  input  logic         D_valid,
  input  logic         SYNC,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic [3:0]   Y_valid,
  output logic         FRAME_done,
  output logic         LOCK,
  output logic         SYNC_err
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [1:0]   ch_q, ch_d;
  logic [W-1:0] y0_q, y0_d;
  logic [W-1:0] y1_q, y1_d;
  logic [W-1:0] y2_q, y2_d;
  logic [W-1:0] y3_q, y3_d;
  logic [3:0]   yv_q, yv_d;
  logic         fd_q, fd_d;
  logic         err_q, err_d;

  // Next-state: framing FSM, channel counter and capture strobes; everything holds on D_valid=0.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    y0_d    = y0_q;
    y1_d    = y1_q;
    y2_d    = y2_q;
    y3_d    = y3_q;
    yv_d    = 4'b0000;
    fd_d    = 1'b0;
    err_d   = 1'b0;
    if (D_valid) begin
      unique case (state_q)
        HUNT: begin
          // Words before the first marker are dropped silently.
          if (SYNC) begin
            y0_d    = D;
            yv_d    = 4'b0001;
            ch_d    = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (ch_q == 2'd0) begin
            if (SYNC) begin
              y0_d = D;
              yv_d = 4'b0001;
              ch_d = 2'd1;
            end else begin
              // Expected a marker and got none: drop the word and re-acquire.
              err_d   = 1'b1;
              ch_d    = 2'd0;
              state_d = HUNT;
            end
          end else if (SYNC) begin
            // Marker arrived early: treat it as the start of a new frame.
            err_d = 1'b1;
            y0_d  = D;
            yv_d  = 4'b0001;
            ch_d  = 2'd1;
          end else begin
            yv_d = 4'b0001 << ch_q;
            ch_d = ch_q + 2'd1;
            unique case (ch_q)
              2'd1:    y1_d = D;
              2'd2:    y2_d = D;
              default: begin
                y3_d = D;
                fd_d = 1'b1;
              end
            endcase
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers, cleared asynchronously so a partial frame is discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HUNT;
      ch_q    <= 2'd0;
      y0_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      y3_q    <= '0;
      yv_q    <= 4'b0000;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      y0_q    <= y0_d;
      y1_q    <= y1_d;
      y2_q    <= y2_d;
      y3_q    <= y3_d;
      yv_q    <= yv_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign Y0         = y0_q;
  assign Y1         = y1_q;
  assign Y2         = y2_q;
  assign Y3         = y3_q;
  assign Y_valid    = yv_q;
  assign FRAME_done = fd_q;
  assign SYNC_err   = err_q;
  assign LOCK       = (state_q == LOCKED);

endmodule

// File: tb/tb_demux_1x4_tdm.sv
// Directed bench for demux_1x4_tdm: framing, gaps, hunt, early/missing sync, async reset.
// Inputs change on the falling edge; outputs are checked 1ns after the rising edge.
module tb_demux_1x4_tdm;

  logic       clk;
  logic       rst_n;
  logic [7:0] D;
  logic       D_valid;
  logic       SYNC;
  logic [7:0] Y0, Y1, Y2, Y3;
  logic [3:0] Y_valid;
  logic       FRAME_done;
  logic       LOCK;
  logic       SYNC_err;

  int vec_cnt = 0;
  int err_cnt = 0;

  demux_1x4_tdm #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .D          (D),
    .D_valid    (D_valid),
    .SYNC       (SYNC),
    .Y0         (Y0),
    .Y1         (Y1),
    .Y2         (Y2),
    .Y3         (Y3),
    .Y_valid    (Y_valid),
    .FRAME_done (FRAME_done),
    .LOCK       (LOCK),
    .SYNC_err   (SYNC_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one valid word for exactly one rising edge, then look at the result.
  task automatic send(input logic [7:0] d, input logic s);
    @(negedge clk);
    D       = d;
    D_valid = 1'b1;
    SYNC    = s;
    @(posedge clk);
    #1;
    D_valid = 1'b0;
    SYNC    = 1'b0;
  endtask

  // Idle cycles; strobes must stay low throughout.
  task automatic gap(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_yv"},  {28'd0, Y_valid}, 32'h0);
      check({tag, "_fd"},  {31'd0, FRAME_done}, 32'h0);
      check({tag, "_err"}, {31'd0, SYNC_err}, 32'h0);
    end
  endtask

  task automatic check_y(input string tag, input logic [7:0] e0, e1, e2, e3);
    check({tag, "_y0"}, {24'd0, Y0}, {24'd0, e0});
    check({tag, "_y1"}, {24'd0, Y1}, {24'd0, e1});
    check({tag, "_y2"}, {24'd0, Y2}, {24'd0, e2});
    check({tag, "_y3"}, {24'd0, Y3}, {24'd0, e3});
  endtask

  task automatic check_flags(input string tag, input logic [3:0] yv, input logic fd, lk, er);
    check({tag, "_yv"},   {28'd0, Y_valid}, {28'd0, yv});
    check({tag, "_fd"},   {31'd0, FRAME_done}, {31'd0, fd});
    check({tag, "_lock"}, {31'd0, LOCK}, {31'd0, lk});
    check({tag, "_err"},  {31'd0, SYNC_err}, {31'd0, er});
  endtask

  initial begin
    rst_n   = 1'b0;
    D       = 8'h00;
    D_valid = 1'b0;
    SYNC    = 1'b0;
    #12;
    check_y("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    check_flags("rst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal back-to-back frame.
    send(8'hA1, 1'b1); check_flags("nom_a1", 4'b0001, 1'b0, 1'b1, 1'b0);
    check("nom_a1_y0", {24'd0, Y0}, 32'hA1);
    send(8'hB2, 1'b0); check_flags("nom_b2", 4'b0010, 1'b0, 1'b1, 1'b0);
    check("nom_b2_y1", {24'd0, Y1}, 32'hB2);
    send(8'hC3, 1'b0); check_flags("nom_c3", 4'b0100, 1'b0, 1'b1, 1'b0);
    send(8'hD4, 1'b0); check_flags("nom_d4", 4'b1000, 1'b1, 1'b1, 1'b0);
    check_y("nom", 8'hA1, 8'hB2, 8'hC3, 8'hD4);
    gap(1, "nom_after");

    // Same framing with three idle cycles between words.
    send(8'h10, 1'b1); check_flags("gap_10", 4'b0001, 1'b0, 1'b1, 1'b0);
    gap(3, "gap1");
    send(8'h20, 1'b0); check_flags("gap_20", 4'b0010, 1'b0, 1'b1, 1'b0);
    gap(3, "gap2");
    send(8'h30, 1'b0); check_flags("gap_30", 4'b0100, 1'b0, 1'b1, 1'b0);
    gap(3, "gap3");
    send(8'h40, 1'b0); check_flags("gap_40", 4'b1000, 1'b1, 1'b1, 1'b0);
    check_y("gap", 8'h10, 8'h20, 8'h30, 8'h40);

    // Missing sync after a complete frame.
    send(8'h99, 1'b0); check_flags("miss", 4'b0000, 1'b0, 1'b0, 1'b1);
    check_y("miss", 8'h10, 8'h20, 8'h30, 8'h40);
    gap(1, "miss_after");

    // Hunt: unmarked words ignored, marker locks.
    send(8'h55, 1'b0); check_flags("hunt_55", 4'b0000, 1'b0, 1'b0, 1'b0);
    send(8'h66, 1'b0); check_flags("hunt_66", 4'b0000, 1'b0, 1'b0, 1'b0);
    check_y("hunt", 8'h10, 8'h20, 8'h30, 8'h40);
    send(8'h77, 1'b1); check_flags("hunt_77", 4'b0001, 1'b0, 1'b1, 1'b0);
    check("hunt_y0", {24'd0, Y0}, 32'h77);
    send(8'h88, 1'b0);
    send(8'h89, 1'b0);
    send(8'h8A, 1'b0); check_flags("hunt_8a", 4'b1000, 1'b1, 1'b1, 1'b0);

    // Early sync on the third word.
    send(8'h11, 1'b1); check_flags("early_11", 4'b0001, 1'b0, 1'b1, 1'b0);
    send(8'h22, 1'b0); check_flags("early_22", 4'b0010, 1'b0, 1'b1, 1'b0);
    send(8'h33, 1'b1); check_flags("early_33", 4'b0001, 1'b0, 1'b1, 1'b1);
    check_y("early", 8'h33, 8'h22, 8'h89, 8'h8A);
    send(8'h44, 1'b0); check_flags("early_44", 4'b0010, 1'b0, 1'b1, 1'b0);
    check("early_44_y1", {24'd0, Y1}, 32'h44);

    // Finish that frame, then reset between the second and third words of the next.
    send(8'h45, 1'b0);
    send(8'h46, 1'b0); check_flags("pre_rst", 4'b1000, 1'b1, 1'b1, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0); check_flags("mid_02", 4'b0010, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_y("arst", 8'h00, 8'h00, 8'h00, 8'h00);
    check_flags("arst", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h03, 1'b0); check_flags("post_03", 4'b0000, 1'b0, 1'b0, 1'b0);
    check("post_03_y0", {24'd0, Y0}, 32'h00);
    send(8'h05, 1'b1); check_flags("post_05", 4'b0001, 1'b0, 1'b1, 1'b0);
    check("post_05_y0", {24'd0, Y0}, 32'h05);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
